lpc_io_target: RTL and testbench

- Parametrised LPC I/O-cycle target. Successor to the fixed-map LPC decode/control pair.
- Decodes host I/O reads and writes to a configurable 16-bit base window of NUM_REGS byte registers, plus one snoop (POST) address.
- Inserts a configurable number of short-wait SYNCs on reads and handles LFRAME aborts.
- Sits between the board LPC pins (tristate split at top level) and the register file / mux.

---
 rtl/lpc_pkg.sv | 38 +++
 rtl/lpc_sync_gen.sv | 33 +++
 rtl/lpc_io_target.sv | 179 +++++++++++++++++
 tb/tb_lpc_io_target.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC I/O-cycle target: state encoding, bus
// nibble constants and the register-window decode helper.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTDIR,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_ADDR3,
        ST_WD0,
        ST_WD1,
        ST_HTAR0,
        ST_HTAR1,
        ST_SYNC,
        ST_RD0,
        ST_RD1,
        ST_PTAR0,
        ST_PTAR1,
        ST_IGNORE
    } lpcState_t;

    localparam logic [3:0] CT_IO_RD   = 4'b0000;
    localparam logic [3:0] CT_IO_WR   = 4'b0010;
    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_SWAIT = 4'h5;
    localparam logic [3:0] LAD_IDLE   = 4'hF;

    // True when addr falls in the window starting at base; mask keeps the
    // bits above the register offset.
    function automatic logic window_hit(input logic [15:0] addr,
                                        input logic [15:0] base,
                                        input logic [15:0] mask);
        return ((addr ^ base) & mask) == 16'h0000;
    endfunction

endpackage

// File: rtl/lpc_sync_gen.sv
// SYNC wait counter: reads get RD_WAIT short-wait nibbles before ready,
// writes go straight to ready.
module lpc_sync_gen
    import lpc_pkg::*;
#(
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic       isRead,
    input  logic       inSync,
    output logic [3:0] syncNibble,
    output logic       waitDone
);

    logic [3:0] waitCnt;

    // Load the wait budget on the way into SYNC, then count down to zero without wrapping
    always_ff @(posedge clk) begin
        if (srst) begin
            waitCnt <= 4'h0;
        end else if (load) begin
            waitCnt <= isRead ? 4'(RD_WAIT) : 4'h0;
        end else if (inSync && (waitCnt != 4'h0)) begin
            waitCnt <= waitCnt - 4'h1;
        end
    end

    assign waitDone   = (waitCnt == 4'h0);
    assign syncNibble = waitDone ? SYNC_READY : SYNC_SWAIT;

endmodule

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes host I/O reads/writes to a byte register
// window plus a write-only POST snoop address, and drives SYNC/data back.
module lpc_io_target
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter int          NUM_REGS   = 32,
    parameter int          AW         = $clog2(NUM_REGS),
    parameter logic [15:0] SNOOP_ADDR = 16'h0080,
    parameter int          RD_WAIT    = 1
) (
    input  logic          LpcClock,
    input  logic          PciReset,
    input  logic          LpcFrame,
    input  logic [3:0]    LpcAdIn,
    output logic [3:0]    LpcAdOut,
    output logic          LpcAdOe,
    output logic          RegWr,
    output logic          RegRd,
    output logic [AW-1:0] RegAddr,
    output logic [7:0]    RegWrData,
    input  logic [7:0]    RegRdData,
    output logic [7:0]    PostData,
    output logic          PostValid
);

    localparam logic [15:0] WIN_MASK = ~16'(NUM_REGS - 1);

    lpcState_t   state;
    logic        isWrite;
    logic        hitWin;
    logic [11:0] addrShift;
    logic [3:0]  dataLo;
    logic [7:0]  rdData;
    logic [15:0] fullAddr;
    logic        ioCycle;
    logic [3:0]  syncNibble;
    logic        waitDone;

    // Address is complete once the last nibble arrives in ADDR3
    assign fullAddr = {addrShift, LpcAdIn};
    assign ioCycle  = (LpcAdIn & 4'b1100) == (CT_IO_RD & 4'b1100);

    lpc_sync_gen #(
        .RD_WAIT(RD_WAIT)
    ) syncGen (
        .clk       (LpcClock),
        .srst      (PciReset),
        .load      ((state == ST_HTAR1) && LpcFrame),
        .isRead    (!isWrite),
        .inSync    (state == ST_SYNC),
        .syncNibble(syncNibble),
        .waitDone  (waitDone)
    );

    // Cycle FSM; a low LFRAME# overrides every state so aborts and restarts need no special path
    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            state     <= ST_IDLE;
            isWrite   <= 1'b0;
            hitWin    <= 1'b0;
            addrShift <= 12'h000;
            dataLo    <= 4'h0;
            rdData    <= 8'h00;
            RegWr     <= 1'b0;
            RegRd     <= 1'b0;
            RegAddr   <= '0;
            RegWrData <= 8'h00;
            PostData  <= 8'h00;
            PostValid <= 1'b0;
        end else begin
            RegWr     <= 1'b0;
            RegRd     <= 1'b0;
            PostValid <= 1'b0;
            if (!LpcFrame) begin
                state <= (LpcAdIn == 4'h0) ? ST_CTDIR : ST_IDLE;
            end else begin
                case (state)
                    ST_CTDIR: begin
                        if (ioCycle) begin
                            isWrite <= (LpcAdIn & 4'b0010) == CT_IO_WR;
                            state   <= ST_ADDR0;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_ADDR0: begin
                        addrShift <= {addrShift[7:0], LpcAdIn};
                        state     <= ST_ADDR1;
                    end
                    ST_ADDR1: begin
                        addrShift <= {addrShift[7:0], LpcAdIn};
                        state     <= ST_ADDR2;
                    end
                    ST_ADDR2: begin
                        addrShift <= {addrShift[7:0], LpcAdIn};
                        state     <= ST_ADDR3;
                    end
                    ST_ADDR3: begin
                        // Window wins over the snoop address; reads of the snoop address are not claimed
                        if (window_hit(fullAddr, BASE_ADDR, WIN_MASK)) begin
                            hitWin  <= 1'b1;
                            RegAddr <= fullAddr[AW-1:0];
                            state   <= isWrite ? ST_WD0 : ST_HTAR0;
                        end else if (isWrite && (fullAddr == SNOOP_ADDR)) begin
                            hitWin <= 1'b0;
                            state  <= ST_WD0;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_WD0: begin
                        dataLo <= LpcAdIn;
                        state  <= ST_WD1;
                    end
                    ST_WD1: begin
                        if (hitWin) begin
                            RegWr     <= 1'b1;
                            RegWrData <= {LpcAdIn, dataLo};
                        end else begin
                            PostValid <= 1'b1;
                            PostData  <= {LpcAdIn, dataLo};
                        end
                        state <= ST_HTAR0;
                    end
                    ST_HTAR0: begin
                        RegRd <= !isWrite;
                        state <= ST_HTAR1;
                    end
                    ST_HTAR1: state <= ST_SYNC;
                    ST_SYNC: begin
                        if (waitDone) begin
                            if (isWrite) begin
                                state <= ST_PTAR0;
                            end else begin
                                rdData <= RegRdData;
                                state  <= ST_RD0;
                            end
                        end
                    end
                    ST_RD0:   state <= ST_RD1;
                    ST_RD1:   state <= ST_PTAR0;
                    ST_PTAR0: state <= ST_PTAR1;
                    ST_PTAR1: state <= ST_IDLE;
                    default:  state <= state;
                endcase
            end
        end
    end

    // LAD drive is a pure function of state so an abort releases the bus on the next cycle
    always_comb begin
        LpcAdOut = LAD_IDLE;
        LpcAdOe  = 1'b0;
        case (state)
            ST_SYNC: begin
                LpcAdOut = syncNibble;
                LpcAdOe  = 1'b1;
            end
            ST_RD0: begin
                LpcAdOut = rdData[3:0];
                LpcAdOe  = 1'b1;
            end
            ST_RD1: begin
                LpcAdOut = rdData[7:4];
                LpcAdOe  = 1'b1;
            end
            ST_PTAR0: begin
                LpcAdOut = LAD_IDLE;
                LpcAdOe  = 1'b1;
            end
            default: begin
                LpcAdOut = LAD_IDLE;
                LpcAdOe  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lpc_io_target.sv
// Self-checking bench for lpc_io_target: directed scenarios then random
// I/O cycles, each checked cycle by cycle against a transaction-level model.
module tb_lpc_io_target;

    localparam logic [15:0] BASE  = 16'h0800;
    localparam logic [15:0] SNOOP = 16'h0080;
    localparam int          NREG  = 32;
    localparam int          W     = 2;
    localparam int          L     = 14 + W;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       frame     = 1'b1;
    logic [3:0] ladIn     = 4'hF;
    logic [7:0] rdDataIn  = 8'h00;
    logic [3:0] ladOut;
    logic       ladOe;
    logic       regWr;
    logic       regRd;
    logic [4:0] regAddr;
    logic [7:0] regWrData;
    logic [7:0] postData;
    logic       postValid;

    int         nCmp = 0;
    int         nErr = 0;
    logic [7:0] mem [NREG];
    logic [7:0] expPost = 8'h00;

    always #15 clk = ~clk;

    lpc_io_target #(
        .BASE_ADDR (BASE),
        .NUM_REGS  (NREG),
        .SNOOP_ADDR(SNOOP),
        .RD_WAIT   (W)
    ) dut (
        .LpcClock (clk),
        .PciReset (rst),
        .LpcFrame (frame),
        .LpcAdIn  (ladIn),
        .LpcAdOut (ladOut),
        .LpcAdOe  (ladOe),
        .RegWr    (regWr),
        .RegRd    (regRd),
        .RegAddr  (regAddr),
        .RegWrData(regWrData),
        .RegRdData(rdDataIn),
        .PostData (postData),
        .PostValid(postValid)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Pulse reset for one edge and check every output holds its reset value.
    task automatic resetCheck();
        @(negedge clk);
        rst = 1'b1; frame = 1'b1; ladIn = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_oe", ladOe, 1'b0);
        chk("rst_lad", ladOut, 4'hF);
        chk("rst_wr", regWr, 1'b0);
        chk("rst_rd", regRd, 1'b0);
        chk("rst_pv", postValid, 1'b0);
        chk("rst_addr", regAddr, 5'd0);
        chk("rst_wdata", regWrData, 8'h00);
        chk("rst_post", postData, 8'h00);
        expPost = 8'h00;
        $display("reset: oe=%0b lad=%h post=%h", ladOe, ladOut, postData);
    endtask

    // One host cycle: START, CT/DIR, 4 address nibbles, 2 data nibbles on writes,
    // 2 turnaround nibbles. cut>0 stops after that many host cycles (abort/reset).
    task automatic runTxn(input logic [3:0] ct, input logic [15:0] addr,
                          input logic [7:0] data, input int cut);
        logic       isW;
        logic       io;
        logic       win;
        logic       snp;
        logic [7:0] rdByte;
        logic       hostFrm [L];
        logic [3:0] hostLad [L];
        logic       expOe   [L];
        logic [3:0] expOut  [L];
        logic       expWr   [L];
        logic       expRd   [L];
        logic       expPv   [L];
        int         ta;
        int         n;
        isW    = ct[1];
        io     = (ct[3:2] == 2'b00);
        win    = io && ((addr & ~16'(NREG - 1)) == BASE);
        snp    = io && isW && !win && (addr == SNOOP);
        rdByte = mem[addr[4:0]];
        for (int k = 0; k < L; k++) begin
            hostFrm[k] = 1'b1; hostLad[k] = 4'hF;
            expOe[k] = 1'b0; expOut[k] = 4'hF;
            expWr[k] = 1'b0; expRd[k] = 1'b0; expPv[k] = 1'b0;
        end
        hostFrm[0] = 1'b0; hostLad[0] = 4'h0;
        hostLad[1] = ct;
        for (int i = 0; i < 4; i++) hostLad[2 + i] = addr[15 - 4 * i -: 4];
        if (isW) begin
            hostLad[6] = data[3:0];
            hostLad[7] = data[7:4];
        end
        // Target owns LAD once the host's two turnaround nibbles are done
        ta = isW ? 10 : 8;
        if (win && isW) expWr[8] = 1'b1;
        if (snp) expPv[8] = 1'b1;
        if (win && !isW) expRd[7] = 1'b1;
        if (win || snp) begin
            if (isW) begin
                expOe[ta] = 1'b1; expOut[ta] = 4'h0;
                expOe[ta + 1] = 1'b1; expOut[ta + 1] = 4'hF;
            end else begin
                for (int j = 0; j < W; j++) begin
                    expOe[ta + j] = 1'b1; expOut[ta + j] = 4'h5;
                end
                expOe[ta + W] = 1'b1;     expOut[ta + W] = 4'h0;
                expOe[ta + W + 1] = 1'b1; expOut[ta + W + 1] = rdByte[3:0];
                expOe[ta + W + 2] = 1'b1; expOut[ta + W + 2] = rdByte[7:4];
                expOe[ta + W + 3] = 1'b1; expOut[ta + W + 3] = 4'hF;
            end
        end
        n = (cut > 0) ? cut : L;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("oe", ladOe, expOe[k]);
            if (expOe[k]) chk("lad", ladOut, expOut[k]);
            chk("wr", regWr, expWr[k]);
            chk("rd", regRd, expRd[k]);
            chk("pv", postValid, expPv[k]);
            if (expWr[k]) begin
                chk("waddr", regAddr, addr[4:0]);
                chk("wdata", regWrData, data);
                mem[addr[4:0]] = data;
            end
            if (expRd[k]) chk("raddr", regAddr, addr[4:0]);
            if (expPv[k]) expPost = data;
            chk("post", postData, expPost);
            frame    = hostFrm[k];
            ladIn    = hostLad[k];
            // Read data is only valid in the cycle the ready SYNC is driven
            rdDataIn = (!isW && (k == 8 + W)) ? rdByte : ~rdByte;
        end
        $display("txn ct=%h addr=%h data=%h win=%0b snoop=%0b cut=%0d errors=%0d",
                 ct, addr, isW ? data : rdByte, win, snp, cut, nErr);
    endtask

    initial begin
        logic [15:0] a;
        int          kind;
        for (int i = 0; i < NREG; i++) mem[i] = 8'($urandom);
        resetCheck();

        runTxn(4'h2, 16'h0803, 8'hA5, 0);
        mem[31] = 8'h3C;
        runTxn(4'h0, 16'h081F, 8'h00, 0);
        runTxn(4'h2, 16'h0080, 8'h3C, 0);
        runTxn(4'h0, 16'h0900, 8'h00, 0);
        runTxn(4'h0, 16'h0080, 8'h00, 0);
        // START during ADDR2 abandons the first cycle
        runTxn(4'h2, 16'h0801, 8'hEE, 4);
        runTxn(4'h2, 16'h0800, 8'h11, 0);
        // Reset lands while the read is in SYNC
        runTxn(4'h0, 16'h0805, 8'h00, 9);
        resetCheck();
        runTxn(4'h2, 16'h0802, 8'h77, 0);
        runTxn(4'h0, 16'h0802, 8'h00, 0);
        runTxn(4'h4, 16'h0804, 8'h00, 0);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: runTxn(4'h2, BASE | 16'($urandom_range(0, NREG - 1)), 8'($urandom), 0);
                1: runTxn(4'h0, BASE | 16'($urandom_range(0, NREG - 1)), 8'h00, 0);
                2: runTxn(4'h2, SNOOP, 8'($urandom), 0);
                3: begin
                    a = 16'($urandom);
                    while (((a & 16'hFFE0) == BASE) || (a == SNOOP)) a = 16'($urandom);
                    runTxn(($urandom_range(0, 1) == 1) ? 4'h2 : 4'h0, a, 8'($urandom), 0);
                end
                default: runTxn(4'(4 + $urandom_range(0, 11)),
                                BASE | 16'($urandom_range(0, NREG - 1)), 8'($urandom), 0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
